// File: rtl/param_datapath.sv
// Parametrised multi-cycle datapath: register file, Hi/Lo, ALU and iterative signed MUL/DIV.
// Optional macro R0_ZERO_EN makes R[0] a constant zero register.
module param_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [3:0]               opcode,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [$clog2(NREGS)-1:0] rs,
    input  logic [$clog2(NREGS)-1:0] rt,
    input  logic [15:0]              imm,
    input  logic [WIDTH-1:0]         in_port,
    output logic [WIDTH-1:0]         out_port,
    output logic [WIDTH-1:0]         result,
    output logic                     result_valid,
    output logic                     busy,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo
);

    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, ITER} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ROL,
        OP_ADDI, OP_MUL, OP_DIV, OP_MFHI, OP_MFLO, OP_IN, OP_OUT, OP_NOP
    } op_t;

    state_t             state;
    op_t                opReg;
    logic [AW-1:0]      rdReg;
    logic [WIDTH-1:0]   aReg, bReg, immReg, inReg;
    logic [WIDTH-1:0]   regFile [NREGS];
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mulProd;
    logic [WIDTH-1:0]   divQuo, divRem;

    logic [WIDTH-1:0]   immSext, aluOut, magA, magB;
    logic [WIDTH-1:0]   quoFinal, remFinal, divRemNext, divQuoNext;
    logic [2*WIDTH-1:0] rolWide, mulNext, mulFinal;
    logic [WIDTH:0]     mulSum, divShift;
    logic [SW-1:0]      sh;
    logic               divGe, wrEn;

    function automatic logic [WIDTH-1:0] magOf(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign op_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        immSext = WIDTH'($signed(imm));
        sh      = bReg[SW-1:0];
        rolWide = {aReg, aReg} << sh;
        case (opReg)
            OP_ADD:  aluOut = aReg + bReg;
            OP_SUB:  aluOut = aReg - bReg;
            OP_AND:  aluOut = aReg & bReg;
            OP_OR:   aluOut = aReg | bReg;
            OP_XOR:  aluOut = aReg ^ bReg;
            OP_SHL:  aluOut = aReg << sh;
            OP_SHR:  aluOut = aReg >> sh;
            OP_ROL:  aluOut = rolWide[2*WIDTH-1:WIDTH];
            OP_ADDI: aluOut = aReg + immReg;
            OP_MFHI: aluOut = hi;
            OP_MFLO: aluOut = lo;
            OP_IN:   aluOut = inReg;
            OP_OUT:  aluOut = aReg;
            default: aluOut = result;
        endcase
`ifdef R0_ZERO_EN
        wrEn = (opReg != OP_OUT) && (opReg != OP_NOP) && (rdReg != '0);
`else
        wrEn = (opReg != OP_OUT) && (opReg != OP_NOP);
`endif
    end

    // One shift-add / restoring-divide step over operand magnitudes, plus final sign fix-up.
    always_comb begin
        magA       = magOf(aReg);
        magB       = magOf(bReg);
        mulSum     = {1'b0, mulProd[2*WIDTH-1:WIDTH]} + (mulProd[0] ? {1'b0, magA} : '0);
        mulNext    = {mulSum, mulProd[WIDTH-1:1]};
        divShift   = {divRem, divQuo[WIDTH-1]};
        divGe      = divShift >= {1'b0, magB};
        divRemNext = WIDTH'(divGe ? divShift - {1'b0, magB} : divShift);
        divQuoNext = {divQuo[WIDTH-2:0], divGe};
        mulFinal   = (aReg[WIDTH-1] ^ bReg[WIDTH-1]) ? -mulProd : mulProd;
        quoFinal   = (aReg[WIDTH-1] ^ bReg[WIDTH-1]) ? -divQuo : divQuo;
        remFinal   = aReg[WIDTH-1] ? -divRem : divRem;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            opReg        <= OP_NOP;
            rdReg        <= '0;
            aReg         <= '0;
            bReg         <= '0;
            immReg       <= '0;
            inReg        <= '0;
            cnt          <= '0;
            mulProd      <= '0;
            divQuo       <= '0;
            divRem       <= '0;
            hi           <= '0;
            lo           <= '0;
            out_port     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) regFile[i] <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        opReg   <= op_t'(opcode);
                        rdReg   <= rd;
                        aReg    <= regFile[rs];
                        bReg    <= regFile[rt];
                        immReg  <= immSext;
                        inReg   <= in_port;
                        cnt     <= '0;
                        mulProd <= {{WIDTH{1'b0}}, magOf(regFile[rt])};
                        divQuo  <= magOf(regFile[rs]);
                        divRem  <= '0;
                        if (op_t'(opcode) == OP_MUL || op_t'(opcode) == OP_DIV) state <= ITER;
                        else state <= EXEC;
                    end
                end
                EXEC: begin
                    if (wrEn) regFile[rdReg] <= aluOut;
                    if (opReg == OP_OUT) out_port <= aReg;
                    result       <= aluOut;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                ITER: begin
                    // WIDTH step cycles, then one extra cycle that only applies signs and writes back.
                    if (cnt == CW'(WIDTH)) begin
                        if (opReg == OP_MUL) begin
                            hi     <= mulFinal[2*WIDTH-1:WIDTH];
                            lo     <= mulFinal[WIDTH-1:0];
                            result <= mulFinal[WIDTH-1:0];
                        end else if (bReg == '0) begin
                            hi     <= aReg;
                            lo     <= '1;
                            result <= '1;
                        end else begin
                            hi     <= remFinal;
                            lo     <= quoFinal;
                            result <= quoFinal;
                        end
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        if (opReg == OP_MUL) begin
                            mulProd <= mulNext;
                        end else begin
                            divRem <= divRemNext;
                            divQuo <= divQuoNext;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
